bmu_issue_queue: RTL and testbench
==================================

Name: bmu_issue_queue

Overview:
- Upstream issue stage for the bit-manipulation unit (BMU).
- Accepts operation requests over a valid/ready handshake and decodes a compact opcode into the BMU one-hot control vector `ap`.
- Buffers requests in a DEPTH-entry FIFO.
- Issues at most one operation per cycle on the BMU input signals: `a_in`, `b_in`, `valid_in`, `ap`, `csr_ren_in`, `csr_rddata_in`, `scan_mode`.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CW, 3, count width, equal to $clog2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_l  input  1  reset, synchronous, active-high (asserted = 1).
- req_valid  input  1  request present.
- req_ready  output  1  queue can accept a request.
- req_op  input  5  opcode, encoding below.
- req_a  input  32  operand 1, signed.
- req_b  input  32  operand 2, signed.
- req_csr_ren  input  1  CSR read enable travelling with the op.
- req_csr_data  input  32  CSR read data travelling with the op.
- issue_stall  input  1  hold issue this cycle.
- flush  input  1  discard all queued and in-flight issue state.
- scan_in  input  1  scan mode; registered once and driven to scan_mode.
- a_in  output  32  BMU operand 1.
- b_in  output  32  BMU operand 2.
- valid_in  output  1  BMU operation valid.
- ap  output  22  BMU control vector. Bit order [21:0]: csr_write, csr_imm, zbb, zbp, zba, zbs, land, lxor, sll, sra, rol, bext, sh3add, add, slt, sub, clz, cpop, siext_h, min, packu, gorc.
- csr_ren_in  output  1  BMU CSR read enable.
- csr_rddata_in  output  32  BMU CSR read data.
- scan_mode  output  1  registered scan_in.
- illegal_op  output  1  one-cycle pulse on a rejected opcode.
- count  output  CW  current FIFO occupancy.

Behaviour:
- Reset, checked at the rising edge while rst_l=1: every output register clears to 0, FIFO becomes empty, count=0.
  - req_ready is then 1, since it is combinational !full.
- Opcode decode (req_op -> asserted ap bits; all other bits 0):
  - 1 land; 2 lxor; 3 land+zbb (ANDN); 4 lxor+zbb (XNOR); 5 sll; 6 sra; 7 rol+zbb.
  - 8 bext+zbs; 9 sh3add+zba; 10 add; 11 slt; 12 sub; 13 clz+zbb; 14 cpop+zbb.
  - 15 siext_h+zbb; 16 min+zbb; 17 packu+zbp; 18 gorc+zbb (ORC.B); 19 csr_write; 20 csr_write+csr_imm.
  - Opcodes 0 and 21-31 are illegal.
- Accept condition: req_valid && req_ready && !flush.
  - Legal opcode: push {decoded ap, a, b, csr_ren, csr_data} into the FIFO.
  - Illegal opcode: no push; illegal_op=1 for exactly the following cycle. The request is consumed, not retried.
- req_ready = (count != DEPTH).
  - When full, no push occurs even if a pop happens in the same cycle.
  - No combinational path exists from issue_stall or flush to req_ready.
- Issue: at each edge, if FIFO is non-empty and !issue_stall and !flush:
  - pop the head;
  - register its fields onto a_in, b_in, ap, csr_ren_in, csr_rddata_in;
  - set valid_in=1.
- No issue at an edge: valid_in=0, ap=0, csr_ren_in=0; a_in, b_in, csr_rddata_in hold their last values.
- Latency: a request accepted at edge N into an empty queue appears with valid_in=1 after edge N+1. There is no bypass.
- Throughput: one issue per cycle; back-to-back issue while the queue is non-empty.
- Simultaneous push and pop (not full): count is unchanged and both take effect.
  - Order is strictly FIFO; pointers wrap modulo DEPTH.
- Flush: at that edge the FIFO empties (count=0), valid_in=0, ap=0, csr_ren_in=0.
  - A same-cycle request is dropped and no illegal_op is raised.
  - Flush has priority over push and pop.
- Reset mid-operation has priority over everything, including flush.
- count updates every edge: +1 on push, -1 on pop, 0 on both or neither. It never exceeds DEPTH and never underflows.

Test Plan:
- Reset then single request (op=10, a=5, b=-3): after 2 edges valid_in=1, ap=22'h000100, a_in=5, b_in=32'hFFFFFFFD; next cycle valid_in=0, ap=0.
- issue_stall held high, push 4 requests (ops 1,2,3,4): count=4, req_ready=0. A 5th request is not accepted. Release stall: issues follow in cycles 1..4 with ap=0x8000, 0x4000, 0x88000, 0x84000, back-to-back; count returns to 0.
- op=0 and op=25 with req_valid=1: no push, illegal_op pulses 1 cycle each, count stays 0, valid_in stays 0.
- op=20, req_csr_ren=1, req_csr_data=0xDEAD_BEEF: issue has ap=22'h300000, csr_ren_in=1, csr_rddata_in=0xDEADBEEF.
- Queue holds 3 entries, assert flush together with a new request: next cycle count=0, valid_in=0, no later issue of any of the 4 ops.
- Continuous push and pop for 10 cycles (no stall) with a=i: issued a_in sequence is 0..9 in order, count constant at 1, pointer wrap covered.

Source files
------------

// File: rtl/bmu_issue_queue_if.sv
// Request and issue signals of the BMU issue queue.
// The slave modport is the queue's view. The master modport is the view of
// whatever drives requests and observes issue.
interface bmu_issue_queue_if #(
    parameter int CW = 3
);
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_csr_ren;
    logic [31:0] req_csr_data;
    logic        issue_stall;
    logic        flush;
    logic        scan_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        valid_in;
    logic [21:0] ap;
    logic        csr_ren_in;
    logic [31:0] csr_rddata_in;
    logic        scan_mode;
    logic        illegal_op;
    logic [CW-1:0] count;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_csr_ren, req_csr_data,
        input  issue_stall, flush, scan_in,
        output req_ready, a_in, b_in, valid_in, ap, csr_ren_in, csr_rddata_in,
        output scan_mode, illegal_op, count
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_csr_ren, req_csr_data,
        output issue_stall, flush, scan_in,
        input  req_ready, a_in, b_in, valid_in, ap, csr_ren_in, csr_rddata_in,
        input  scan_mode, illegal_op, count
    );
endinterface

// File: rtl/bmu_issue_queue.sv
// BMU issue queue.
// Decodes compact opcodes into the BMU one-hot control vector and buffers
// them in a DEPTH-entry FIFO. It issues at most one registered operation per cycle.
module bmu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic               clk,
    input logic               rst_l,
    bmu_issue_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    // ap bit positions
    localparam int ApCsrWrite = 21;
    localparam int ApCsrImm   = 20;
    localparam int ApZbb      = 19;
    localparam int ApZbp      = 18;
    localparam int ApZba      = 17;
    localparam int ApZbs      = 16;
    localparam int ApLand     = 15;
    localparam int ApLxor     = 14;
    localparam int ApSll      = 13;
    localparam int ApSra      = 12;
    localparam int ApRol      = 11;
    localparam int ApBext     = 10;
    localparam int ApSh3add   = 9;
    localparam int ApAdd      = 8;
    localparam int ApSlt      = 7;
    localparam int ApSub      = 6;
    localparam int ApClz      = 5;
    localparam int ApCpop     = 4;
    localparam int ApSiextH   = 3;
    localparam int ApMin      = 2;
    localparam int ApPacku    = 1;
    localparam int ApGorc     = 0;

    typedef struct packed {
        logic [21:0] ap;
        logic [31:0] a;
        logic [31:0] b;
        logic        csr_ren;
        logic [31:0] csr_data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   a_in_q, a_in_d, b_in_q, b_in_d, csr_rddata_q, csr_rddata_d;
    logic [21:0]   ap_q, ap_d;
    logic          valid_in_q, valid_in_d, csr_ren_q, csr_ren_d;
    logic          scan_mode_q, scan_mode_d, illegal_op_q, illegal_op_d;

    logic [21:0]   dec_ap;
    logic          dec_legal;
    logic          full, accept, push, pop;
    entry_t        head;

    // Opcode decode into the one-hot control vector
    always_comb begin
        dec_ap    = '0;
        dec_legal = 1'b1;
        case (bus.req_op)
            5'd1:  dec_ap[ApLand] = 1'b1;
            5'd2:  dec_ap[ApLxor] = 1'b1;
            5'd3:  begin dec_ap[ApLand] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd4:  begin dec_ap[ApLxor] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd5:  dec_ap[ApSll] = 1'b1;
            5'd6:  dec_ap[ApSra] = 1'b1;
            5'd7:  begin dec_ap[ApRol] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd8:  begin dec_ap[ApBext] = 1'b1; dec_ap[ApZbs] = 1'b1; end
            5'd9:  begin dec_ap[ApSh3add] = 1'b1; dec_ap[ApZba] = 1'b1; end
            5'd10: dec_ap[ApAdd] = 1'b1;
            5'd11: dec_ap[ApSlt] = 1'b1;
            5'd12: dec_ap[ApSub] = 1'b1;
            5'd13: begin dec_ap[ApClz] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd14: begin dec_ap[ApCpop] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd15: begin dec_ap[ApSiextH] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd16: begin dec_ap[ApMin] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd17: begin dec_ap[ApPacku] = 1'b1; dec_ap[ApZbp] = 1'b1; end
            5'd18: begin dec_ap[ApGorc] = 1'b1; dec_ap[ApZbb] = 1'b1; end
            5'd19: dec_ap[ApCsrWrite] = 1'b1;
            5'd20: begin dec_ap[ApCsrWrite] = 1'b1; dec_ap[ApCsrImm] = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    // FIFO push/pop and issue-register next state; flush overrides both
    always_comb begin
        full   = (count_q == CW'(DEPTH));
        accept = bus.req_valid && !full && !bus.flush;
        push   = accept && dec_legal;
        pop    = (count_q != '0) && !bus.issue_stall && !bus.flush;
        head   = mem_q[rd_ptr_q];

        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        a_in_d       = a_in_q;
        b_in_d       = b_in_q;
        csr_rddata_d = csr_rddata_q;
        valid_in_d   = 1'b0;
        ap_d         = '0;
        csr_ren_d    = 1'b0;
        scan_mode_d  = bus.scan_in;
        illegal_op_d = accept && !dec_legal;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{ap: dec_ap, a: bus.req_a, b: bus.req_b,
                                    csr_ren: bus.req_csr_ren, csr_data: bus.req_csr_data};
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + PW'(1);
                a_in_d       = head.a;
                b_in_d       = head.b;
                ap_d         = head.ap;
                csr_ren_d    = head.csr_ren;
                csr_rddata_d = head.csr_data;
                valid_in_d   = 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst_l) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            a_in_q       <= '0;
            b_in_q       <= '0;
            csr_rddata_q <= '0;
            valid_in_q   <= 1'b0;
            ap_q         <= '0;
            csr_ren_q    <= 1'b0;
            scan_mode_q  <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            a_in_q       <= a_in_d;
            b_in_q       <= b_in_d;
            csr_rddata_q <= csr_rddata_d;
            valid_in_q   <= valid_in_d;
            ap_q         <= ap_d;
            csr_ren_q    <= csr_ren_d;
            scan_mode_q  <= scan_mode_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign bus.req_ready     = !full;
    assign bus.a_in          = a_in_q;
    assign bus.b_in          = b_in_q;
    assign bus.valid_in      = valid_in_q;
    assign bus.ap            = ap_q;
    assign bus.csr_ren_in    = csr_ren_q;
    assign bus.csr_rddata_in = csr_rddata_q;
    assign bus.scan_mode     = scan_mode_q;
    assign bus.illegal_op    = illegal_op_q;
    assign bus.count         = count_q;
endmodule

// File: tb/tb_bmu_issue_queue.sv
// Self-checking bench for bmu_issue_queue.
// A queue-based reference model predicts issue, and a negedge monitor checks it via a scoreboard.
module tb_bmu_issue_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk;
    logic rst_l;
    bmu_issue_queue_if #(.CW(CW)) bus ();

    bmu_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] ap;
        logic [31:0] a;
        logic [31:0] b;
        logic        ren;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];   // model of queue contents
    ent_t sb[$];   // expected issues, oldest first

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;
    bit exp_valid, exp_ill, exp_scan;
    int exp_count;
    logic [31:0] hold_a, hold_b, hold_d;

    // Opcode table: control bits named in the BMU's [21:0] order
    function automatic logic [21:0] ref_ap(input logic [4:0] op);
        logic [21:0] CSRW, CSRI, ZBB, ZBP, ZBA, ZBS, LAND, LXOR, SLL, SRA, ROL;
        logic [21:0] BEXT, SH3, ADD, SLT, SUB, CLZ, CPOP, SIEXT, MIN, PACKU, GORC;
        CSRW = 22'h200000; CSRI = 22'h100000; ZBB  = 22'h080000; ZBP   = 22'h040000;
        ZBA  = 22'h020000; ZBS  = 22'h010000; LAND = 22'h008000; LXOR  = 22'h004000;
        SLL  = 22'h002000; SRA  = 22'h001000; ROL  = 22'h000800; BEXT  = 22'h000400;
        SH3  = 22'h000200; ADD  = 22'h000100; SLT  = 22'h000080; SUB   = 22'h000040;
        CLZ  = 22'h000020; CPOP = 22'h000010; SIEXT = 22'h000008; MIN  = 22'h000004;
        PACKU = 22'h000002; GORC = 22'h000001;
        case (op)
            5'd1:  return LAND;
            5'd2:  return LXOR;
            5'd3:  return LAND | ZBB;
            5'd4:  return LXOR | ZBB;
            5'd5:  return SLL;
            5'd6:  return SRA;
            5'd7:  return ROL | ZBB;
            5'd8:  return BEXT | ZBS;
            5'd9:  return SH3 | ZBA;
            5'd10: return ADD;
            5'd11: return SLT;
            5'd12: return SUB;
            5'd13: return CLZ | ZBB;
            5'd14: return CPOP | ZBB;
            5'd15: return SIEXT | ZBB;
            5'd16: return MIN | ZBB;
            5'd17: return PACKU | ZBP;
            5'd18: return GORC | ZBB;
            5'd19: return CSRW;
            5'd20: return CSRW | CSRI;
            default: return 22'h0;  // illegal
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one step per rising edge, using the inputs held stable since the last negedge
    always @(posedge clk) begin
        ent_t e;
        logic [21:0] dap;
        bit acc;
        if (rst_l) begin
            mq.delete();
            sb.delete();
            exp_valid = 0; exp_ill = 0; exp_scan = 0;
            hold_a = '0; hold_b = '0; hold_d = '0;
            armed = 1'b1;
        end else if (bus.flush) begin
            mq.delete();
            exp_valid = 0; exp_ill = 0; exp_scan = bus.scan_in;
        end else begin
            acc = bus.req_valid && (mq.size() < DEPTH);
            dap = ref_ap(bus.req_op);
            exp_valid = 0;
            if (mq.size() > 0 && !bus.issue_stall) begin
                e = mq.pop_front();
                sb.push_back(e);
                exp_valid = 1;
                hold_a = e.a; hold_b = e.b; hold_d = e.d;
            end
            if (acc && dap != '0) begin
                e = '{ap: dap, a: bus.req_a, b: bus.req_b, ren: bus.req_csr_ren,
                      d: bus.req_csr_data};
                mq.push_back(e);
            end
            exp_ill  = acc && (dap == '0);
            exp_scan = bus.scan_in;
        end
        exp_count = mq.size();
    end

    // Monitor: pop the scoreboard whenever the DUT presents an issue
    always @(negedge clk) begin
        ent_t e;
        if (armed) begin
            chk("valid_in", 32'(bus.valid_in), 32'(exp_valid));
            if (bus.valid_in) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_issue: got ap=%h, required no issue", bus.ap);
                end else begin
                    e = sb.pop_front();
                    chk("issue_ap", 32'(bus.ap), 32'(e.ap));
                    chk("issue_a", bus.a_in, e.a);
                    chk("issue_b", bus.b_in, e.b);
                    chk("issue_csr_ren", 32'(bus.csr_ren_in), 32'(e.ren));
                    chk("issue_csr_data", bus.csr_rddata_in, e.d);
                end
            end else begin
                chk("idle_ap", 32'(bus.ap), 32'h0);
                chk("idle_csr_ren", 32'(bus.csr_ren_in), 32'h0);
                chk("hold_a", bus.a_in, hold_a);
                chk("hold_b", bus.b_in, hold_b);
                chk("hold_csr_data", bus.csr_rddata_in, hold_d);
            end
            chk("count", 32'(bus.count), 32'(exp_count));
            chk("req_ready", 32'(bus.req_ready), 32'(exp_count != DEPTH));
            chk("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
            chk("scan_mode", 32'(bus.scan_mode), 32'(exp_scan));
        end
    end

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ren, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_a        = a;
        bus.req_b        = b;
        bus.req_csr_ren  = ren;
        bus.req_csr_data = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst_l            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_op       = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.req_csr_ren  = 1'b0;
        bus.req_csr_data = '0;
        bus.issue_stall  = 1'b0;
        bus.flush        = 1'b0;
        bus.scan_in      = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b0;

        // Single add with a negative operand
        send(5'd10, 32'd5, -32'sd3, 1'b0, 32'h0);
        idle(3);

        // Fill while stalled; the fifth request must be refused, then drain back-to-back
        bus.issue_stall = 1'b1;
        for (int i = 1; i <= 4; i++) send(5'(i), 32'(i), 32'(i * 3), 1'b0, 32'h0);
        send(5'd5, 32'h55, 32'h66, 1'b0, 32'h0);
        bus.issue_stall = 1'b0;
        idle(6);

        // Illegal opcodes
        send(5'd0, 32'h1, 32'h2, 1'b0, 32'h0);
        idle(1);
        send(5'd25, 32'h3, 32'h4, 1'b0, 32'h0);
        idle(2);

        // CSR write-immediate carrying read data
        send(5'd20, 32'h7, 32'h8, 1'b1, 32'hDEAD_BEEF);
        idle(3);

        // Flush with three queued plus a same-cycle request
        bus.issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) send(5'd12, 32'(100 + i), 32'h9, 1'b0, 32'h0);
        bus.flush = 1'b1;
        send(5'd0, 32'h200, 32'h9, 1'b0, 32'h0);
        bus.flush = 1'b0;
        bus.issue_stall = 1'b0;
        idle(4);

        // Streaming push/pop with pointer wrap
        for (int i = 0; i < 10; i++) send(5'd10, 32'(i), 32'h1, 1'b0, 32'h0);
        idle(3);

        // Randomized traffic including stalls, flushes, scan toggles and the odd reset
        for (int c = 0; c < 600; c++) begin
            bus.req_valid    = ($urandom_range(0, 99) < 65);
            bus.req_op       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31))
                                                           : 5'($urandom_range(0, 20));
            bus.req_a        = $urandom;
            bus.req_b        = $urandom;
            bus.req_csr_ren  = 1'($urandom_range(0, 1));
            bus.req_csr_data = $urandom;
            bus.issue_stall  = ($urandom_range(0, 99) < 30);
            bus.flush        = ($urandom_range(0, 99) < 3);
            bus.scan_in      = 1'($urandom_range(0, 1));
            rst_l            = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst_l           = 1'b0;
        bus.issue_stall = 1'b0;
        bus.flush       = 1'b0;
        idle(8);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        chk("model_drained", 32'(bus.count), 32'(mq.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
